// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Define MD_UNIT_MADD_EN to enable the MADD/MADDU accumulate ops.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MC  = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DC  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    state_t             state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] pend;
    logic               pend_wr;

    logic is_mul;
    logic is_div;
    logic is_mthi;
    logic is_mtlo;
    logic sgn;
`ifdef MD_UNIT_MADD_EN
    logic is_madd;
`endif
    logic accept;
    logic arith;
    logic expire;

    logic [2*WIDTH-1:0] ea;
    logic [2*WIDTH-1:0] eb;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] res;
    logic               res_wr;
    logic               na;
    logic               nb;
    logic               bz;
    logic [WIDTH-1:0]   ua;
    logic [WIDTH-1:0]   ub;
    logic [WIDTH-1:0]   ud;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;

    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        sgn     = 1'b0;
`ifdef MD_UNIT_MADD_EN
        is_madd = 1'b0;
`endif
        case (op)
            3'd0: begin
                is_mul = 1'b1;
                sgn    = 1'b1;
            end
            3'd1: is_mul = 1'b1;
            3'd2: begin
                is_div = 1'b1;
                sgn    = 1'b1;
            end
            3'd3: is_div  = 1'b1;
            3'd4: is_mthi = 1'b1;
            3'd5: is_mtlo = 1'b1;
`ifdef MD_UNIT_MADD_EN
            3'd6: begin
                is_mul  = 1'b1;
                is_madd = 1'b1;
                sgn     = 1'b1;
            end
            3'd7: begin
                is_mul  = 1'b1;
                is_madd = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign arith  = is_mul | is_div;
    assign accept = start & ~busy & ~flush;
    assign expire = (state == RUN) && (cnt == ONE);

    // Sign-extending to 2*WIDTH makes the truncated product correct for both signs.
    always_comb begin
        ea   = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb   = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod = ea * eb;
        na   = sgn & a[WIDTH-1];
        nb   = sgn & b[WIDTH-1];
        bz   = (b == '0);
        ua   = na ? -a : a;
        ub   = nb ? -b : b;
        ud   = bz ? WIDTH'(1) : ub;
        uq   = ua / ud;
        ur   = ua % ud;
        res_wr = 1'b1;
        if (is_div) begin
            res    = {(na ? -ur : ur), ((na ^ nb) ? -uq : uq)};
            res_wr = ~bz;
        end else begin
            res = prod;
`ifdef MD_UNIT_MADD_EN
            if (is_madd)
                res = prod + {hi, lo};
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && arith) state_nx = RUN;
            RUN:     if (flush || expire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            cnt     <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    if (is_mthi) hi <= a;
                    if (is_mtlo) lo <= a;
                    if (arith) begin
                        pend    <= res;
                        pend_wr <= res_wr;
                        cnt     <= is_div ? DC : MC;
                    end
                end
            end else if (flush) begin
                cnt     <= '0;
                pend    <= '0;
                pend_wr <= 1'b0;
            end else if (expire) begin
                if (pend_wr) {hi, lo} <= pend;
                done    <= 1'b1;
                cnt     <= '0;
                pend    <= '0;
                pend_wr <= 1'b0;
            end else begin
                cnt <= cnt - ONE;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic model.
// Also exercises a WIDTH=16 instance for short-latency corner cases.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        s_start;
    logic        s_flush;
    logic [2:0]  s_op;
    logic [15:0] s_a;
    logic [15:0] s_b;
    logic        s_busy;
    logic        s_done;
    logic [15:0] s_hi;
    logic [15:0] s_lo;

    int tests = 0;
    int fails = 0;
    logic [31:0] eh = '0;
    logic [31:0] el = '0;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a),
        .b(s_b), .flush(s_flush), .busy(s_busy), .done(s_done),
        .hi(s_hi), .lo(s_lo)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat(input logic [2:0] o);
        int n;
        n = 0;
        if (o == 3'd0 || o == 3'd1) n = MC;
        if (o == 3'd2 || o == 3'd3) n = DC;
`ifdef MD_UNIT_MADD_EN
        if (o == 3'd6 || o == 3'd7) n = MC;
`endif
        return n;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int fl);
        logic [63:0] r;
        logic        upd;
        longint      sx;
        longint      sy;
        int          n;
        int          last;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        r   = {eh, el};
        upd = 1'b1;
        n   = lat(o);
        case (o)
            3'd0: r = 64'(sx * sy);
            3'd1: r = {32'h0, x} * {32'h0, y};
            3'd2: if (y == 0) upd = 1'b0;
                  else r = {32'(sx % sy), 32'(sx / sy)};
            3'd3: if (y == 0) upd = 1'b0;
                  else r = {x % y, x / y};
            3'd4: r = {x, el};
            3'd5: r = {eh, x};
`ifdef MD_UNIT_MADD_EN
            3'd6: r = {eh, el} + 64'(sx * sy);
            3'd7: r = {eh, el} + {32'h0, x} * {32'h0, y};
`endif
            default: ;
        endcase
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        if (n == 0) begin
            start = 1'b0;
            {eh, el} = r;
            check("no_busy", busy, 1'b0);
            check("no_done", done, 1'b0);
            check("hi_imm", hi, eh);
            check("lo_imm", lo, el);
        end else begin
            last = (fl != 0) ? fl : n;
            for (int i = 1; i <= last; i++) begin
                if (i > 1) @(negedge clk);
                check("busy_win", busy, 1'b1);
                check("hold_hilo", {hi, lo}, {eh, el});
                check("done_early", done, 1'b0);
                start = 1'($urandom % 2);
                op    = 3'd4;
                a     = $urandom;
                if (i == fl) flush = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
            if (fl != 0) begin
                check("flush_busy", busy, 1'b0);
                check("flush_done", done, 1'b0);
                check("flush_hilo", {hi, lo}, {eh, el});
            end else begin
                if (upd) {eh, el} = r;
                check("end_busy", busy, 1'b0);
                check("done_pulse", done, 1'b1);
                check("res_hi", hi, eh);
                check("res_lo", lo, el);
            end
            @(negedge clk);
            check("done_once", done, 1'b0);
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        int          rf;
        int          rn;
        logic        seen;
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op = '0; a = '0; b = '0;
        s_start = 1'b0; s_flush = 1'b0;
        s_op = '0; s_a = '0; s_b = '0;
        #1;
        check("rst_state", {busy, done, hi, lo}, '0);
        check("rst_state16", {s_busy, s_done, s_hi, s_lo}, '0);

        repeat (3) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd4;
        a     = 32'hA5A5_0001;
        @(negedge clk);
        start = 1'b0;
        eh = 32'hA5A5_0001;
        check("first_accept", hi, eh);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
        check("mult_vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd0, 0);
        check("div0_vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'h1234_5678;
        @(negedge clk);
        check("mt_busy", busy, 1'b0);
        op = 3'd5; a = 32'h9;
        @(negedge clk);
        start = 1'b0;
        eh = 32'h1234_5678; el = 32'h9;
        check("mt_busy2", busy, 1'b0);
        check("mt_hilo", {hi, lo}, 64'h1234_5678_0000_0009);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
        run_op(3'd0, 32'h0001_0000, 32'h0001_0000, MC);
        run_op(3'd2, 32'd100, 32'd7, DC);

        run_op(3'd4, 32'h0, 32'h0, 0);
        run_op(3'd5, 32'hFFFF_FFFF, 32'h0, 0);
        run_op(3'd7, 32'd1, 32'd1, 0);
`ifdef MD_UNIT_MADD_EN
        check("maddu_vec", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        check("maddu_off", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid", {busy, done, hi, lo}, '0);
        eh = '0; el = '0;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (DC + 2) begin
            @(negedge clk);
            if (busy || done) seen = 1'b1;
        end
        check("rst_abort", {seen, hi, lo}, '0);

        repeat (30) begin
            ro = 3'($urandom % 8);
            rx = $urandom;
            ry = ($urandom % 5 == 0) ? 32'd0 : $urandom;
            if ($urandom % 3 == 0) ry = ry % 16;
            rn = lat(ro);
            rf = (rn > 0 && $urandom % 4 == 0) ? $urandom_range(rn, 1) : 0;
            run_op(ro, rx, ry, rf);
        end

        @(negedge clk);
        s_start = 1'b1; s_op = 3'd0; s_a = 16'h8000; s_b = 16'h8000;
        @(negedge clk);
        s_start = 1'b0;
        check("w16_busy", s_busy, 1'b1);
        check("w16_hold", {s_hi, s_lo}, 32'h0);
        @(negedge clk);
        check("w16_mult", {s_busy, s_done, s_hi, s_lo}, {2'b01, 32'h4000_0000});
        s_start = 1'b1; s_op = 3'd2; s_a = 16'h8000; s_b = 16'hFFFF;
        @(negedge clk);
        s_start = 1'b0;
        check("w16_dbusy", s_busy, 1'b1);
        repeat (2) @(negedge clk);
        check("w16_dhold", {s_busy, s_hi, s_lo}, {1'b1, 32'h4000_0000});
        @(negedge clk);
        check("w16_div", {s_busy, s_done, s_hi, s_lo}, {2'b01, 32'h0000_8000});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
